// File: rtl/speech_vote_decider.sv
// speech_vote_decider: majority-votes per-frame keyword classes over a VAD window
// into a speech_rec command that is held for HOLD_CYCLES clocks.
module speech_vote_decider #(
   parameter int CNT_W       = 8,
   parameter int MIN_VOTES   = 4,
   parameter int MAX_FRAMES  = 200,
   parameter int HOLD_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       vad,
   input  logic       frame_valid,
   input  logic [1:0] frame_class,
   output logic [1:0] speech_rec,
   output logic       rec_valid,
   output logic       busy
);
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam logic [CNT_W-1:0] MIN_V = CNT_W'(MIN_VOTES);
   localparam logic [CNT_W-1:0] MAX_F = CNT_W'(MAX_FRAMES);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, COLLECT, DECIDE, HOLD, QUIET} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] on_cnt_q, on_cnt_d, off_cnt_q, off_cnt_d;
   logic [CNT_W-1:0] oth_cnt_q, oth_cnt_d, frame_cnt_q, frame_cnt_d;
   logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
   logic [1:0]       speech_rec_q, speech_rec_d;
   logic             rec_valid_q, rec_valid_d, busy_q, busy_d, take;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   always_comb begin
      state_d      = state_q;
      on_cnt_d     = on_cnt_q;
      off_cnt_d    = off_cnt_q;
      oth_cnt_d    = oth_cnt_q;
      frame_cnt_d  = frame_cnt_q;
      hold_cnt_d   = hold_cnt_q;
      speech_rec_d = speech_rec_q;
      rec_valid_d  = 1'b0;
      take         = 1'b0;
      case (state_q)
         IDLE: begin
            on_cnt_d    = '0;
            off_cnt_d   = '0;
            oth_cnt_d   = '0;
            frame_cnt_d = '0;
            if (vad) begin
               state_d = COLLECT;
               take    = frame_valid;
            end
         end
         COLLECT: begin
            take    = vad & frame_valid;
            state_d = vad ? COLLECT : DECIDE;
         end
         DECIDE: begin
            speech_rec_d = (on_cnt_q > off_cnt_q && on_cnt_q >= MIN_V) ? 2'd1 :
                           (off_cnt_q > on_cnt_q && off_cnt_q >= MIN_V) ? 2'd2 : 2'd0;
            rec_valid_d  = 1'b1;
            hold_cnt_d   = HOLD_LAST;
            state_d      = HOLD;
         end
         HOLD: begin
            hold_cnt_d   = (hold_cnt_q == '0) ? hold_cnt_q : hold_cnt_q - HW'(1);
            speech_rec_d = (hold_cnt_q == '0) ? 2'd0 : speech_rec_q;
            state_d      = (hold_cnt_q != '0) ? HOLD : vad ? QUIET : IDLE;
         end
         QUIET: state_d = vad ? QUIET : IDLE;
         default: state_d = IDLE;
      endcase
      // class 3 falls into the "other" bucket so it can never vote
      if (take) begin
         frame_cnt_d = sat_inc(frame_cnt_d);
         on_cnt_d    = (frame_class == 2'd1) ? sat_inc(on_cnt_d) : on_cnt_d;
         off_cnt_d   = (frame_class == 2'd2) ? sat_inc(off_cnt_d) : off_cnt_d;
         oth_cnt_d   = (frame_class == 2'd0 || frame_class == 2'd3) ? sat_inc(oth_cnt_d) : oth_cnt_d;
         state_d     = (frame_cnt_d >= MAX_F) ? QUIET : state_d;
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         on_cnt_q     <= '0;
         off_cnt_q    <= '0;
         oth_cnt_q    <= '0;
         frame_cnt_q  <= '0;
         hold_cnt_q   <= '0;
         speech_rec_q <= 2'd0;
         rec_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         on_cnt_q     <= on_cnt_d;
         off_cnt_q    <= off_cnt_d;
         oth_cnt_q    <= oth_cnt_d;
         frame_cnt_q  <= frame_cnt_d;
         hold_cnt_q   <= hold_cnt_d;
         speech_rec_q <= speech_rec_d;
         rec_valid_q  <= rec_valid_d;
         busy_q       <= busy_d;
      end
   end

   assign speech_rec = speech_rec_q;
   assign rec_valid  = rec_valid_q;
   assign busy       = busy_q;
endmodule

// File: tb/tb_speech_vote_decider.sv
// tb_speech_vote_decider: utterance vectors for speech_vote_decider, expected
// decisions queued at stimulus time and popped when rec_valid fires.
module tb_speech_vote_decider;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       vad = 1'b0;
   logic       frame_valid = 1'b0;
   logic [1:0] frame_class = 2'd0;
   logic [1:0] speech_rec;
   logic       rec_valid, busy;

   int checks = 0;
   int errors = 0;
   logic [1:0] exp_q[$];

   typedef struct {
      int         n_on;
      int         n_off;
      int         n_oth;
      int         n_three;
      bit         together;
      logic [1:0] exp;
      string      name;
   } vec_t;

   vec_t tbl[12];

   speech_vote_decider dut (
      .clk(clk), .rst(rst), .vad(vad), .frame_valid(frame_valid),
      .frame_class(frame_class), .speech_rec(speech_rec),
      .rec_valid(rec_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // One utterance; rst_at > 0 pulses rst that many cycles into HOLD.
   task automatic run_utt(input int n_on, input int n_off, input int n_oth, input int n_three,
                          input bit together, input logic [1:0] exp, input string name,
                          input int rst_at);
      int         cls[$];
      int         n;
      bit         bad;
      logic [1:0] want;
      for (int i = 0; i < n_on; i++) cls.push_back(1);
      for (int i = 0; i < n_off; i++) cls.push_back(2);
      for (int i = 0; i < n_oth; i++) cls.push_back(0);
      for (int i = 0; i < n_three; i++) cls.push_back(3);
      exp_q.push_back(exp);
      @(posedge clk); #1;
      vad = 1'b1;
      if (together && cls.size() > 0) begin
         frame_valid = 1'b1;
         frame_class = 2'(cls.pop_front());
      end
      @(posedge clk); #1;
      while (cls.size() > 0) begin
         frame_valid = 1'b1;
         frame_class = 2'(cls.pop_front());
         @(posedge clk); #1;
      end
      frame_valid = 1'b0;
      frame_class = 2'd0;
      vad = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rec_valid && n < 40);
      chk({name, "_latency"}, n, 3);
      want = exp_q.pop_front();
      chk({name, "_rec"}, int'(speech_rec), int'(want));
      if (rst_at > 0) begin
         repeat (rst_at) @(negedge clk);
         chk({name, "_pre_rst"}, int'(speech_rec), int'(want));
         rst = 1'b1;
         @(negedge clk);
         chk({name, "_rst_rec"}, int'(speech_rec), 0);
         chk({name, "_rst_busy"}, int'(busy), 0);
         rst = 1'b0;
      end else begin
         bad = 1'b0;
         repeat (15) begin
            @(negedge clk);
            if (speech_rec !== want || rec_valid !== 1'b0 || busy !== 1'b1) bad = 1'b1;
         end
         chk({name, "_hold"}, int'(bad), 0);
         @(negedge clk);
         chk({name, "_after_rec"}, int'(speech_rec), 0);
         chk({name, "_after_busy"}, int'(busy), 0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      bit bad;
      tbl[0]  = '{6, 0, 0, 0, 1'b0, 2'd1, "on6"};
      tbl[1]  = '{3, 5, 0, 0, 1'b0, 2'd2, "off5_on3"};
      tbl[2]  = '{4, 4, 0, 0, 1'b0, 2'd0, "tie4"};
      tbl[3]  = '{3, 0, 0, 0, 1'b0, 2'd0, "on3_below_min"};
      tbl[4]  = '{4, 0, 0, 0, 1'b0, 2'd1, "on4_min"};
      tbl[5]  = '{3, 4, 10, 0, 1'b0, 2'd2, "off4_oth10"};
      tbl[6]  = '{4, 0, 0, 5, 1'b0, 2'd1, "on4_cls3x5"};
      tbl[7]  = '{0, 4, 0, 5, 1'b0, 2'd2, "off4_cls3x5"};
      tbl[8]  = '{0, 0, 0, 0, 1'b0, 2'd0, "no_frames"};
      tbl[9]  = '{199, 0, 0, 0, 1'b0, 2'd1, "on199"};
      tbl[10] = '{5, 4, 0, 0, 1'b0, 2'd1, "on5_off4"};
      tbl[11] = '{4, 0, 0, 0, 1'b1, 2'd1, "vad_with_frame"};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_rec", int'(speech_rec), 0);
      chk("reset_valid", int'(rec_valid), 0);
      chk("reset_busy", int'(busy), 0);
      rst = 1'b0;

      foreach (tbl[i])
         run_utt(tbl[i].n_on, tbl[i].n_off, tbl[i].n_oth, tbl[i].n_three,
                 tbl[i].together, tbl[i].exp, tbl[i].name, 0);

      run_utt(6, 0, 0, 0, 1'b0, 2'd1, "rst_mid_hold", 4);

      // 200 frames abort the utterance; vad stays high in QUIET.
      @(posedge clk); #1;
      vad = 1'b1;
      for (int i = 0; i < 200; i++) begin
         frame_valid = 1'b1;
         frame_class = 2'd1;
         @(posedge clk); #1;
      end
      bad = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (rec_valid !== 1'b0 || busy !== 1'b1 || speech_rec !== 2'd0) bad = 1'b1;
      end
      chk("abort_quiet", int'(bad), 0);
      frame_valid = 1'b0;
      vad = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("abort_idle_busy", int'(busy), 0);
      bad = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (rec_valid !== 1'b0 || speech_rec !== 2'd0) bad = 1'b1;
      end
      chk("abort_no_rec", int'(bad), 0);
      run_utt(0, 5, 0, 0, 1'b0, 2'd2, "after_abort", 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
